mem_port_arbiter: RTL and testbench

- Shares the single instruction/data memory port between the fetch stage (IF) and the load/store unit (D).
- Sits between the fetch unit, the LSU and the memory/bus interface.
- Allows one transaction in flight at a time.
- Drives the stall signal that freezes the PC register and the pipeline while the memory port is busy or owned by the other requester.

---
 rtl/cotm32_pkg.sv | 18 +
 rtl/arb_prio_sel.sv | 38 +++
 rtl/mem_port_arbiter_chk.sv | 37 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cotm32_pkg.sv
// Shared types and widths for the cotm32 core memory-port arbitration.
package cotm32_pkg;

  localparam int XLEN         = 32;
  localparam int ARB_STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_D  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Winner selection between fetch and load/store requests. D normally has
// priority; once D has won D_STREAK_MAX times in a row against a waiting
// fetch, the fetch side is forced through.
module arb_prio_sel
  import cotm32_pkg::*;
#(
  parameter int D_STREAK_MAX = 4
) (
  input  logic                    if_req,
  input  logic                    d_req,
  input  logic [ARB_STREAK_W-1:0] streak,
  output logic                    grant_if,
  output logic                    grant_d
);

  localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(D_STREAK_MAX);

  // Pick at most one winner from the current requests and streak count.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (if_req && d_req) begin
      if (streak == STREAK_MAX) begin
        grant_if = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else if (if_req) begin
      grant_if = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// Bus protocol checks on the shared memory port (simulation only).
module mem_port_arbiter_chk (
  input logic i_clk,
  input logic i_rst,
  input logic mem_req,
  input logic mem_gnt,
  input logic mem_rvalid,
  input logic in_idle,
  input logic in_rsp,
  input logic if_rvalid,
  input logic d_rvalid
);

  logic post_rst;

  // Remember that we are in the IDLE stretch right after a reset, where a
  // late response from an abandoned transaction may still show up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      post_rst <= 1'b1;
    end else if (!in_idle) begin
      post_rst <= 1'b0;
    end else begin
      post_rst <= post_rst;
    end
  end

  a_gnt_only_with_req : assert property (@(posedge i_clk) disable iff (i_rst)
    mem_gnt |-> mem_req);

  a_rvalid_only_in_rsp : assert property (@(posedge i_clk) disable iff (i_rst)
    mem_rvalid |-> (in_rsp || (in_idle && post_rst)));

  a_single_rvalid : assert property (@(posedge i_clk) disable iff (i_rst)
    !(if_rvalid && d_rvalid));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the LSU.
// One transaction in flight; the pipeline stalls while its request waits.
module mem_port_arbiter #(
  parameter int D_STREAK_MAX = 4,
  parameter int XLEN         = cotm32_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  input  logic            i_if_flush,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [3:0]      i_d_be,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  output logic            o_d_rvalid,
  output logic [XLEN-1:0] o_d_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_stall
);

  import cotm32_pkg::*;

  localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(D_STREAK_MAX);

  arb_state_t              state;
  arb_state_t              next_state;
  arb_owner_t              owner;
  logic                    discard;
  logic [ARB_STREAK_W-1:0] streak;
  logic                    lat_we;
  logic [3:0]              lat_be;
  logic [XLEN-1:0]         lat_addr;
  logic [XLEN-1:0]         lat_wdata;
  logic                    if_live;
  logic                    grant_if;
  logic                    grant_d;
  logic                    arb_go;
  logic                    rsp_now;

  // A fetch being redirected this cycle does not compete.
  assign if_live = i_if_req & ~i_if_flush;
  assign arb_go  = (state == ARB_IDLE) & (grant_if | grant_d);
  assign rsp_now = (state == ARB_RSP) & i_mem_rvalid;

  arb_prio_sel #(
    .D_STREAK_MAX(D_STREAK_MAX)
  ) u_prio_sel (
    .if_req  (if_live),
    .d_req   (i_d_req),
    .streak  (streak),
    .grant_if(grant_if),
    .grant_d (grant_d)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state: arbitrate, wait for grant, wait for response.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: next_state = arb_go ? ARB_REQ : ARB_IDLE;
      ARB_REQ:  next_state = i_mem_gnt ? ARB_RSP : ARB_REQ;
      ARB_RSP:  next_state = i_mem_rvalid ? ARB_IDLE : ARB_RSP;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Capture the winner's transaction so the bus sees stable fields until grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner     <= ARB_OWN_IF;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (arb_go && grant_d) begin
      owner     <= ARB_OWN_D;
      lat_we    <= i_d_we;
      lat_be    <= i_d_be;
      lat_addr  <= i_d_addr;
      lat_wdata <= i_d_wdata;
    end else if (arb_go) begin
      owner     <= ARB_OWN_IF;
      lat_we    <= 1'b0;
      lat_be    <= 4'hF;
      lat_addr  <= i_if_addr;
      lat_wdata <= '0;
    end else begin
      owner     <= owner;
      lat_we    <= lat_we;
      lat_be    <= lat_be;
      lat_addr  <= lat_addr;
      lat_wdata <= lat_wdata;
    end
  end

  // Count consecutive D wins taken while a fetch was waiting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      streak <= '0;
    end else if (arb_go && grant_d && i_if_req) begin
      streak <= (streak == STREAK_MAX) ? streak : streak + ARB_STREAK_W'(1);
    end else if (arb_go) begin
      streak <= '0;
    end else begin
      streak <= streak;
    end
  end

  // Mark an in-flight fetch as stale once a redirect hits it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      discard <= 1'b0;
    end else if ((state == ARB_IDLE) || rsp_now) begin
      discard <= 1'b0;
    end else if ((owner == ARB_OWN_IF) && i_if_flush) begin
      discard <= 1'b1;
    end else begin
      discard <= discard;
    end
  end

  // FSM outputs: bus drive, response routing and pipeline stall.
  always_comb begin
    o_mem_req   = (state == ARB_REQ);
    o_mem_we    = lat_we;
    o_mem_be    = lat_be;
    o_mem_addr  = lat_addr;
    o_mem_wdata = lat_wdata;
    o_if_rvalid = rsp_now & (owner == ARB_OWN_IF) & ~discard & ~i_if_flush;
    o_d_rvalid  = rsp_now & (owner == ARB_OWN_D);
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;
    o_stall     = (i_if_req & ~o_if_rvalid) | (i_d_req & ~o_d_rvalid);
  end

  mem_port_arbiter_chk u_chk (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .mem_req   (o_mem_req),
    .mem_gnt   (i_mem_gnt),
    .mem_rvalid(i_mem_rvalid),
    .in_idle   (state == ARB_IDLE),
    .in_rsp    (state == ARB_RSP),
    .if_rvalid (o_if_rvalid),
    .d_rvalid  (o_d_rvalid)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic            i_clk;
  logic            i_rst;
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            i_if_flush;
  logic            o_if_rvalid;
  logic [XLEN-1:0] o_if_rdata;
  logic            i_d_req;
  logic            i_d_we;
  logic [3:0]      i_d_be;
  logic [XLEN-1:0] i_d_addr;
  logic [XLEN-1:0] i_d_wdata;
  logic            o_d_rvalid;
  logic [XLEN-1:0] o_d_rdata;
  logic            o_mem_req;
  logic            o_mem_we;
  logic [3:0]      o_mem_be;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic            i_mem_gnt;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_stall;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.D_STREAK_MAX(SMAX), .XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_if_req = 1'b0; i_if_addr = 32'h0; i_if_flush = 1'b0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_be = 4'h0; i_d_addr = 32'h0; i_d_wdata = 32'h0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b1;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0h exp=0", o_mem_req); end
    checks++; if ({o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !== 69'h0) begin errors++; $display("FAIL rst_mem_fields got we=%0h be=%0h addr=%0h wdata=%0h exp=0", o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata); end
    checks++; if ({o_if_rvalid, o_d_rvalid, o_stall} !== 3'b000) begin errors++; $display("FAIL rst_flags got ifv=%0h dv=%0h stall=%0h exp=0", o_if_rvalid, o_d_rvalid, o_stall); end
    checks++; if ({o_if_rdata, o_d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got if=%0h d=%0h exp=0", o_if_rdata, o_d_rdata); end
  endtask

  task automatic test_if_fetch();
    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0100;
    @(negedge i_clk);
    checks++; if ({o_stall, o_mem_req} !== 2'b10) begin errors++; $display("FAIL t1_c0 got stall=%0h req=%0h exp stall=1 req=0", o_stall, o_mem_req); end
    next_cycle();
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_mem_we, o_mem_be} !== 6'b1_0_1111) begin errors++; $display("FAIL t1_c1_req got req=%0h we=%0h be=%0h exp 1/0/f", o_mem_req, o_mem_we, o_mem_be); end
    checks++; if (o_mem_addr !== 32'h100) begin errors++; $display("FAIL t1_addr got=%0h exp=100", o_mem_addr); end
    next_cycle(); i_mem_gnt = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_stall} !== 2'b11) begin errors++; $display("FAIL t1_c2 got req=%0h stall=%0h exp 1/1", o_mem_req, o_stall); end
    next_cycle(); i_mem_gnt = 1'b0;
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_stall, o_if_rvalid} !== 3'b010) begin errors++; $display("FAIL t1_c3 got req=%0h stall=%0h ifv=%0h exp 0/1/0", o_mem_req, o_stall, o_if_rvalid); end
    next_cycle(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0013;
    @(negedge i_clk);
    checks++; if ({o_if_rvalid, o_stall, o_d_rvalid} !== 3'b100) begin errors++; $display("FAIL t1_c4 got ifv=%0h stall=%0h dv=%0h exp 1/0/0", o_if_rvalid, o_stall, o_d_rvalid); end
    checks++; if (o_if_rdata !== 32'h13) begin errors++; $display("FAIL t1_rdata got=%0h exp=13", o_if_rdata); end
    next_cycle(); i_mem_rvalid = 1'b0; i_if_req = 1'b0;
    @(negedge i_clk);
    checks++; if ({o_if_rvalid, o_if_rdata, o_mem_req} !== 34'h0) begin errors++; $display("FAIL t1_c5 got ifv=%0h rdata=%0h req=%0h exp 0", o_if_rvalid, o_if_rdata, o_mem_req); end
  endtask

  task automatic test_d_first();
    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0104;
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_be = 4'b0011; i_d_addr = 32'h8000_0004; i_d_wdata = 32'hDEAD_BEEF;
    next_cycle(); i_mem_gnt = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_mem_we, o_mem_be} !== 6'b1_1_0011) begin errors++; $display("FAIL t2_d_req got req=%0h we=%0h be=%0h exp 1/1/3", o_mem_req, o_mem_we, o_mem_be); end
    checks++; if ({o_mem_addr, o_mem_wdata} !== {32'h8000_0004, 32'hDEAD_BEEF}) begin errors++; $display("FAIL t2_d_fields got addr=%0h wdata=%0h exp 80000004/deadbeef", o_mem_addr, o_mem_wdata); end
    next_cycle(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
    @(negedge i_clk);
    checks++; if ({o_d_rvalid, o_if_rvalid, o_stall} !== 3'b101) begin errors++; $display("FAIL t2_d_done got dv=%0h ifv=%0h stall=%0h exp 1/0/1", o_d_rvalid, o_if_rvalid, o_stall); end
    next_cycle(); i_mem_rvalid = 1'b0; i_d_req = 1'b0;
    next_cycle(); i_mem_gnt = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h104}) begin errors++; $display("FAIL t2_if_next got req=%0h we=%0h be=%0h addr=%0h exp 1/0/f/104", o_mem_req, o_mem_we, o_mem_be, o_mem_addr); end
    next_cycle(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0093;
    @(negedge i_clk);
    checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h93}) begin errors++; $display("FAIL t2_if_data got ifv=%0h rdata=%0h exp 1/93", o_if_rvalid, o_if_rdata); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_streak();
    logic [9:0] exp_d;
    exp_d = 10'b0111101111; // bit k = 1 means D wins transaction k
    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h1000;
    i_d_req = 1'b1; i_d_addr = 32'h2000; i_d_we = 1'b0; i_d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      next_cycle(); i_mem_gnt = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_mem_addr !== (exp_d[k] ? 32'h2000 : 32'h1000) || o_mem_req !== 1'b1) begin
        errors++; $display("FAIL t3_order_%0d got req=%0h addr=%0h exp_d=%0d", k, o_mem_req, o_mem_addr, exp_d[k]);
      end
      next_cycle(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77 + k;
      @(negedge i_clk);
      checks++;
      if ({o_d_rvalid, o_if_rvalid} !== {exp_d[k], ~exp_d[k]}) begin
        errors++; $display("FAIL t3_route_%0d got dv=%0h ifv=%0h exp_d=%0d", k, o_d_rvalid, o_if_rvalid, exp_d[k]);
      end
      next_cycle(); i_mem_rvalid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h200;
    next_cycle(); i_mem_gnt = 1'b1;
    next_cycle(); i_mem_gnt = 1'b0; i_if_flush = 1'b1; i_if_req = 1'b0;
    next_cycle(); i_if_flush = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234;
    @(negedge i_clk);
    checks++; if ({o_if_rvalid, o_if_rdata, o_d_rvalid} !== 34'h0) begin errors++; $display("FAIL t4_dropped got ifv=%0h rdata=%0h dv=%0h exp 0", o_if_rvalid, o_if_rdata, o_d_rvalid); end
    next_cycle(); i_mem_rvalid = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h300;
    next_cycle(); i_mem_gnt = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL t4_refetch got req=%0h addr=%0h exp 1/300", o_mem_req, o_mem_addr); end
    next_cycle(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_5555;
    @(negedge i_clk);
    checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h5555}) begin errors++; $display("FAIL t4_data got ifv=%0h rdata=%0h exp 1/5555", o_if_rvalid, o_if_rdata); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h400;
    next_cycle(); i_mem_gnt = 1'b1;
    next_cycle(); i_mem_gnt = 1'b0; i_rst = 1'b1; i_if_req = 1'b0;
    next_cycle(); i_rst = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hABCD;
    @(negedge i_clk);
    checks++; if ({o_if_rvalid, o_d_rvalid, o_stall, o_mem_req} !== 4'b0000) begin errors++; $display("FAIL t5_flags got ifv=%0h dv=%0h stall=%0h req=%0h exp 0", o_if_rvalid, o_d_rvalid, o_stall, o_mem_req); end
    checks++; if ({o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata} !== 133'h0) begin errors++; $display("FAIL t5_data got addr=%0h be=%0h ifd=%0h dd=%0h exp 0", o_mem_addr, o_mem_be, o_if_rdata, o_d_rdata); end
    next_cycle(); i_mem_rvalid = 1'b0; i_d_req = 1'b1; i_d_addr = 32'h500; i_d_be = 4'hF;
    next_cycle(); i_mem_gnt = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 32'h500}) begin errors++; $display("FAIL t5_rearb got req=%0h we=%0h addr=%0h exp 1/0/500", o_mem_req, o_mem_we, o_mem_addr); end
    next_cycle(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BAD_F00D;
    @(negedge i_clk);
    checks++; if ({o_d_rvalid, o_d_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL t5_load got dv=%0h rdata=%0h exp 1/badf00d", o_d_rvalid, o_d_rdata); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_gnt_stall();
    do_reset();
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_be = 4'b1100; i_d_addr = 32'h600; i_d_wdata = 32'hCAFE_0000;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      i_d_addr = $urandom; i_d_wdata = $urandom; i_d_be = 4'($urandom);
      i_mem_gnt = (c == 5);
      @(negedge i_clk);
      checks++;
      if ({o_mem_req, o_mem_be, o_mem_addr, o_mem_wdata, o_stall} !== {1'b1, 4'b1100, 32'h600, 32'hCAFE_0000, 1'b1}) begin
        errors++; $display("FAIL t6_hold_%0d got req=%0h be=%0h addr=%0h wdata=%0h stall=%0h", c, o_mem_req, o_mem_be, o_mem_addr, o_mem_wdata, o_stall);
      end
    end
    next_cycle(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_d_rvalid, o_stall} !== 2'b10) begin errors++; $display("FAIL t6_done got dv=%0h stall=%0h exp 1/0", o_d_rvalid, o_stall); end
    next_cycle(); clear_inputs();
  endtask

  // Randomized run: the model tracks one transaction as a record
  // (in flight, accepted by memory, owner, stale) plus the D win streak.
  task automatic test_random();
    bit busy, granted, is_d, dropped, ife, e_req, e_resp, e_ifv, e_dv, e_stall;
    int streak;
    logic [XLEN-1:0] t_addr, t_wdata;
    logic t_we;
    logic [3:0] t_be;
    busy = 0; granted = 0; is_d = 0; dropped = 0; streak = 0;
    t_addr = 0; t_wdata = 0; t_we = 0; t_be = 0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      i_rst = (($urandom % 300) == 0);
      i_if_req = (($urandom % 4) != 0);
      i_if_addr = $urandom & 32'hFFFF_FFFC;
      i_if_flush = (($urandom % 12) == 0);
      i_d_req = (($urandom % 3) != 0);
      i_d_we = 1'($urandom);
      i_d_be = 4'($urandom);
      i_d_addr = $urandom;
      i_d_wdata = $urandom;
      i_mem_gnt = (busy && !granted) ? (($urandom % 2) == 0) : 1'b0;
      i_mem_rvalid = (busy && granted) ? (($urandom % 3) == 0) : 1'b0;
      i_mem_rdata = $urandom;
      @(negedge i_clk);
      e_req = busy && !granted;
      e_resp = busy && granted && i_mem_rvalid;
      e_ifv = e_resp && !is_d && !dropped && !i_if_flush;
      e_dv = e_resp && is_d;
      e_stall = (i_if_req && !e_ifv) || (i_d_req && !e_dv);
      checks++;
      if (o_mem_req !== e_req || o_stall !== e_stall) begin
        errors++; $display("FAIL rnd_req_stall n=%0d got req=%0h stall=%0h exp req=%0h stall=%0h", n, o_mem_req, o_stall, e_req, e_stall);
      end
      if (e_req) begin
        checks++;
        if ({o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !== {t_we, t_be, t_addr, t_wdata}) begin
          errors++; $display("FAIL rnd_fields n=%0d got we=%0h be=%0h addr=%0h wdata=%0h exp we=%0h be=%0h addr=%0h wdata=%0h", n, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, t_we, t_be, t_addr, t_wdata);
        end
      end
      checks++;
      if ({o_if_rvalid, o_d_rvalid} !== {e_ifv, e_dv} || o_if_rdata !== (e_ifv ? i_mem_rdata : 32'h0) || o_d_rdata !== (e_dv ? i_mem_rdata : 32'h0)) begin
        errors++; $display("FAIL rnd_rsp n=%0d got ifv=%0h dv=%0h ifd=%0h dd=%0h exp ifv=%0h dv=%0h data=%0h", n, o_if_rvalid, o_d_rvalid, o_if_rdata, o_d_rdata, e_ifv, e_dv, i_mem_rdata);
      end
      if (i_rst) begin
        busy = 0; granted = 0; dropped = 0; streak = 0;
        t_addr = 0; t_wdata = 0; t_we = 0; t_be = 0;
      end else if (!busy) begin
        ife = i_if_req && !i_if_flush;
        if (ife || i_d_req) begin
          is_d = i_d_req && !(ife && streak == SMAX);
          if (is_d && i_if_req) streak = (streak < SMAX) ? streak + 1 : SMAX;
          else streak = 0;
          t_we = is_d ? i_d_we : 1'b0;
          t_be = is_d ? i_d_be : 4'hF;
          t_addr = is_d ? i_d_addr : i_if_addr;
          t_wdata = is_d ? i_d_wdata : 32'h0;
          busy = 1; granted = 0; dropped = 0;
        end
      end else if (!granted) begin
        if (i_mem_gnt) granted = 1;
        if (i_if_flush && !is_d) dropped = 1;
      end else if (i_mem_rvalid) begin
        busy = 0; granted = 0; dropped = 0;
      end else if (i_if_flush && !is_d) begin
        dropped = 1;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    i_rst = 1'b1;
    test_reset();
    test_if_fetch();
    test_d_first();
    test_streak();
    test_flush();
    test_reset_mid();
    test_gnt_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
